// File: rtl/pci_pkg.sv
// Shared PCI definitions: command codes, FSM state encoding, C/BE# idle value.
package pci_pkg;
  localparam logic [3:0] CMD_READ  = 4'b0110;
  localparam logic [3:0] CMD_WRITE = 4'b0111;
  localparam logic [3:0] CBE_IDLE  = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ABORT,
    ST_TURN
  } pci_state_e;

  // Anything that is not the write command is sequenced as a read.
  function automatic logic cmd_is_write(input logic [3:0] cmd);
    return cmd == CMD_WRITE;
  endfunction
endpackage

// File: rtl/pci_ad_driver.sv
// Tri-state AD driver. The enable is registered so the bus is released
// cleanly on state changes and immediately on reset.
module pci_ad_driver (
  input  logic        clk,
  input  logic        rst,
  input  logic        oe_d,
  input  logic [31:0] dout,
  inout  wire  [31:0] ad
);
  logic oe_q;

  // Output-enable register, cleared asynchronously so AD floats during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) oe_q <= 1'b0;
    else     oe_q <= oe_d;
  end

  assign ad = oe_q ? dout : 32'bz;
endmodule

// File: rtl/pci_initiator.sv
// PCI bus-master sequencer: address phase, single/burst data phases,
// master abort on DEVSEL# timeout, and one bus-idle turnaround cycle.
module pci_initiator
  import pci_pkg::*;
#(
  parameter int MAX_LEN   = 16,
  parameter int LEN_W     = 5,
  parameter int DEVSEL_TO = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cmd,
  input  logic [31:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_be,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             err,
  output logic             frame_n,
  output logic [3:0]       cbe_n,
  inout  wire  [31:0]      ad,
  output logic             irdy_n,
  input  logic             trdy_n,
  input  logic             devsel_n
);
  localparam int TO_W = $clog2(DEVSEL_TO + 1);
  localparam logic [TO_W-1:0]  TO_LIM = TO_W'(DEVSEL_TO);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  pci_state_e       state_q, state_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d, rem_q, rem_d;
  logic [TO_W-1:0]  to_q, to_d, to_inc;
  logic             claimed_q, claimed_d;
  logic             abort_q, abort_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             is_wr, xfer, oe_d;

  assign is_wr  = cmd_is_write(cmd_q);
  assign to_inc = to_q + 1'b1;
  assign xfer   = (state_q == ST_DATA) & ~irdy_n & ~trdy_n & ~devsel_n;

  // Bus-side decode of the registered state. Write data, byte enables and
  // IRDY# follow the head of the write stream so an empty stream stalls.
  // FRAME# only rises together with IRDY# on the final beat.
  always_comb begin
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    cbe_n   = CBE_IDLE;
    unique case (state_q)
      ST_ADDR: begin
        frame_n = 1'b0;
        cbe_n   = ~cmd_q;
      end
      ST_DATA: begin
        irdy_n  = is_wr ? ~wr_valid : 1'b0;
        cbe_n   = is_wr ? ~wr_be : 4'b0000;
        frame_n = (rem_q == LEN_ONE) & ~irdy_n;
      end
      ST_ABORT: irdy_n = 1'b0;
      default: ;
    endcase
  end

  // Next-state, beat counting, DEVSEL# timeout and read capture.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    len_d      = len_q;
    rem_d      = rem_q;
    to_d       = to_q;
    claimed_d  = claimed_q;
    abort_d    = abort_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: if (req_valid) begin
        cmd_d   = req_cmd;
        addr_d  = req_addr;
        if (req_len == '0)         len_d = LEN_ONE;
        else if (req_len > LEN_MAX) len_d = LEN_MAX;
        else                       len_d = req_len;
        state_d = ST_ADDR;
      end
      ST_ADDR: begin
        rem_d     = len_q;
        to_d      = '0;
        claimed_d = 1'b0;
        abort_d   = 1'b0;
        state_d   = ST_DATA;
      end
      ST_DATA: begin
        if (!devsel_n) claimed_d = 1'b1;
        if (xfer) begin
          rem_d = rem_q - 1'b1;
          if (!is_wr) begin
            rd_data_d  = ad;
            rd_valid_d = 1'b1;
          end
          if (rem_q == LEN_ONE) state_d = ST_TURN;
        end else if (!claimed_q && devsel_n) begin
          // A DEVSEL# seen on the expiry edge takes the other branch above.
          to_d = to_inc;
          if (to_inc == TO_LIM) begin
            state_d = ST_ABORT;
            abort_d = 1'b1;
          end
        end
      end
      ST_ABORT: state_d = ST_TURN;
      ST_TURN:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      to_q       <= '0;
      claimed_q  <= 1'b0;
      abort_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      to_q       <= to_d;
      claimed_q  <= claimed_d;
      abort_q    <= abort_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign oe_d = (state_d == ST_ADDR) | ((state_d == ST_DATA) & cmd_is_write(cmd_d));

  pci_ad_driver u_ad (
    .clk  (clk),
    .rst  (rst),
    .oe_d (oe_d),
    .dout ((state_q == ST_ADDR) ? addr_q : wr_data),
    .ad   (ad)
  );

  assign req_ready = (state_q == ST_IDLE) & ~rst;
  assign wr_ready  = xfer & is_wr;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = (state_q == ST_TURN);
  assign err       = (state_q == ST_TURN) & abort_q;
endmodule

// File: tb/tb_pci_initiator.sv
// Bench for pci_initiator: a transaction-level model walks each request
// through address, data beats, abort and turnaround, publishing the expected
// bus values per cycle; a negedge process compares the DUT against them.
module tb_pci_initiator;
  import pci_pkg::*;
  localparam int MAX_LEN = 16, LEN_W = 5, DEVSEL_TO = 5;

  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [3:0] req_cmd = '0;
  logic [31:0] req_addr = '0;
  logic [LEN_W-1:0] req_len = '0;
  logic [31:0] wr_data = '0;
  logic [3:0] wr_be = '0;
  logic wr_valid = 1'b0, wr_ready;
  logic [31:0] rd_data;
  logic rd_valid, done, err, frame_n, irdy_n;
  logic [3:0] cbe_n;
  wire  [31:0] ad;
  logic trdy_n = 1'b1, devsel_n = 1'b1;
  logic [31:0] tb_val = '0;

  // expected values for the current cycle
  logic e_frame_n = 1, e_irdy_n = 1, e_ad_drv = 0, e_req_ready = 0;
  logic e_wr_ready = 0, e_rd_valid = 0, e_done = 0, e_err = 0;
  logic [3:0] e_cbe_n = 4'hf;
  logic [31:0] e_ad = '0, e_rd_data = '0, last_rd = '0;
  logic chk_en = 1'b0;

  int n_chk = 0, n_err = 0;
  logic pin_go = 1'b0;
  string pin_name = "";
  logic [31:0] pin_act = '0, pin_exp = '0;

  int n_wrr = 0, n_rdv = 0, n_done = 0, n_errd = 0, n_irdy = 0, n_busy = 0;
  logic [3:0] addr_cbe = '0;
  logic prev_frame = 1'b1;
  int s_wrr, s_rdv, s_done, s_errd, s_irdy, s_busy;

  logic [35:0] wrq[$];
  logic [31:0] rdq[$];

  // The bench plays target and bus keeper whenever the master must float AD.
  assign ad = e_ad_drv ? 32'bz : tb_val;

  always #5 clk = ~clk;

  pci_initiator #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .DEVSEL_TO(DEVSEL_TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_be(wr_be), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .frame_n(frame_n), .cbe_n(cbe_n), .ad(ad), .irdy_n(irdy_n),
    .trdy_n(trdy_n), .devsel_n(devsel_n));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process: model expectations plus literal pin checks.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("frame_n", frame_n, e_frame_n);
      chk("irdy_n", irdy_n, e_irdy_n);
      chk("cbe_n", cbe_n, e_cbe_n);
      chk("ad", ad, e_ad_drv ? e_ad : tb_val);
      chk("req_ready", req_ready, e_req_ready);
      chk("wr_ready", wr_ready, e_wr_ready);
      chk("rd_valid", rd_valid, e_rd_valid);
      chk("rd_data", rd_data, e_rd_data);
      chk("done", done, e_done);
      chk("err", err, e_err);
    end
    if (pin_go) chk(pin_name, pin_act, pin_exp);
  end

  // Event counters used by the literal checks.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_ready) n_wrr <= n_wrr + 1;
      if (rd_valid) n_rdv <= n_rdv + 1;
      if (done) n_done <= n_done + 1;
      if (done && err) n_errd <= n_errd + 1;
      if (!irdy_n) n_irdy <= n_irdy + 1;
      if (!req_ready) n_busy <= n_busy + 1;
      if (prev_frame && !frame_n) addr_cbe <= cbe_n;
    end
    prev_frame <= frame_n;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp);
    pin_name = nm; pin_act = act; pin_exp = exp; pin_go = 1'b1;
    cyc();
    pin_go = 1'b0;
  endtask

  task automatic snap();
    s_wrr = n_wrr; s_rdv = n_rdv; s_done = n_done;
    s_errd = n_errd; s_irdy = n_irdy; s_busy = n_busy;
  endtask

  task automatic set_idle();
    e_frame_n = 1; e_irdy_n = 1; e_cbe_n = CBE_IDLE; e_ad_drv = 0; e_ad = '0;
    e_req_ready = 1; e_wr_ready = 0; e_rd_valid = 0; e_done = 0; e_err = 0;
    e_rd_data = last_rd;
    req_valid = 0; trdy_n = 1; devsel_n = 1; wr_valid = 0; tb_val = $urandom();
  endtask

  // One request end to end. devsel_dly: DATA cycles before DEVSEL# goes low;
  // first_wait: forced TRDY# waits up front; p_wait/p_gap: random wait %;
  // gap_beat/gap_len: forced write-stream gap; rst_beat: reset during that beat.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [LEN_W-1:0] len_in,
                         input int devsel_dly, input int first_wait, input int p_wait,
                         input int gap_beat, input int gap_len, input int p_gap, input int rst_beat);
    int len, rem, to, beats, dcyc, gap_left, waits_left;
    bit claimed, ab, pend_rv, gap_used, xfer, wv, irdy;
    logic [3:0] cmd;
    len = (len_in == 0) ? 1 : ((int'(len_in) > MAX_LEN) ? MAX_LEN : int'(len_in));
    cmd = wr ? CMD_WRITE : CMD_READ;
    while (wrq.size() < len) wrq.push_back({4'($urandom()), 32'($urandom())});
    while (rdq.size() < len) rdq.push_back($urandom());
    // accept cycle
    set_idle();
    req_valid = 1; req_cmd = cmd; req_addr = addr; req_len = len_in;
    cyc();
    // address phase; request inputs scrambled to prove they were latched
    req_valid = 0; req_addr = $urandom(); req_cmd = 4'($urandom()); req_len = LEN_W'($urandom());
    e_req_ready = 0; e_frame_n = 0; e_irdy_n = 1; e_cbe_n = ~cmd; e_ad_drv = 1; e_ad = addr;
    cyc();
    rem = len; to = 0; beats = 0; dcyc = 0; gap_left = 0; waits_left = first_wait;
    claimed = 0; ab = 0; pend_rv = 0; gap_used = 0;
    forever begin
      devsel_n = (dcyc < devsel_dly);
      if (waits_left > 0) begin trdy_n = 1; waits_left--; end
      else trdy_n = ($urandom_range(99) < p_wait);
      if (wr && beats == gap_beat && !gap_used) begin gap_left = gap_len; gap_used = 1; end
      if (gap_left > 0) begin wv = 0; gap_left--; end
      else wv = ($urandom_range(99) >= p_gap);
      wr_valid = wv;
      if (wr) begin wr_data = wrq[0][31:0]; wr_be = wrq[0][35:32]; end
      irdy = wr ? !wv : 1'b0;
      xfer = !irdy && !trdy_n && !devsel_n;
      e_irdy_n = irdy;
      e_frame_n = (rem == 1) && !irdy;
      e_cbe_n = wr ? ~wr_be : 4'b0000;
      e_ad_drv = wr; e_ad = wr_data;
      e_wr_ready = wr && xfer;
      e_rd_valid = pend_rv; e_rd_data = last_rd;
      tb_val = (!wr && !trdy_n) ? rdq[0] : $urandom();
      if (beats == rst_beat) begin
        #1 rst = 1;
        last_rd = '0; set_idle(); e_req_ready = 0;
        cyc(); cyc();
        rst = 0; set_idle();
        wrq.delete(); rdq.delete();
        return;
      end
      cyc();
      dcyc++;
      pend_rv = 0;
      if (!devsel_n) claimed = 1;
      if (xfer) begin
        if (wr) void'(wrq.pop_front());
        else begin last_rd = rdq.pop_front(); pend_rv = 1; end
        rem--; beats++;
        if (rem == 0) break;
      end else if (!claimed) begin
        to++;
        if (to == DEVSEL_TO) begin ab = 1; break; end
      end
    end
    if (ab) begin
      set_idle(); e_req_ready = 0; e_irdy_n = 0;
      cyc();
    end
    set_idle(); e_req_ready = 0; e_done = 1; e_err = ab; e_rd_valid = pend_rv;
    cyc();
    set_idle();
    wrq.delete(); rdq.delete();
  endtask

  initial begin
    #1 rst = 1;
    set_idle(); e_req_ready = 0; chk_en = 1;
    cyc(); cyc(); cyc();
    rst = 0; set_idle();
    cyc();

    // zero-wait write burst
    snap();
    wrq.push_back({4'hf, 32'hffffffff}); wrq.push_back({4'hf, 32'd133}); wrq.push_back({4'hf, 32'd176});
    run_txn(1, 32'd1000, 3, 0, 0, 0, -1, 0, 0, -1);
    pin("wr3_addr_cbe", 32'(addr_cbe), 32'h8);
    pin("wr3_wr_ready_cnt", n_wrr - s_wrr, 3);
    pin("wr3_busy_cycles", n_busy - s_busy, 5);
    pin("wr3_err_cnt", n_errd - s_errd, 0);

    // single read with two TRDY# waits
    snap();
    rdq.push_back(32'd133);
    run_txn(0, 32'd1000, 1, 0, 2, 0, -1, 0, 0, -1);
    pin("rd1_data", rd_data, 32'd133);
    pin("rd1_rd_valid_cnt", n_rdv - s_rdv, 1);
    pin("rd1_irdy_low", n_irdy - s_irdy, 3);

    // no target: master abort
    snap();
    run_txn(0, 32'h40, 1, 1000, 0, 0, -1, 0, 0, -1);
    pin("abort_irdy_low", n_irdy - s_irdy, 6);
    pin("abort_done", n_done - s_done, 1);
    pin("abort_err", n_errd - s_errd, 1);
    pin("abort_rd_valid", n_rdv - s_rdv, 0);

    // DEVSEL# on the expiry edge is a claim; one cycle later is an abort
    snap();
    run_txn(1, 32'h80, 2, 4, 6, 0, -1, 0, 0, -1);
    pin("devsel_edge_err", n_errd - s_errd, 0);
    pin("devsel_edge_wr_ready", n_wrr - s_wrr, 2);
    snap();
    run_txn(1, 32'h84, 2, 5, 0, 0, -1, 0, 0, -1);
    pin("devsel_late_err", n_errd - s_errd, 1);

    // write-stream gap mid-burst
    snap();
    run_txn(1, 32'h100, 4, 0, 0, 0, 2, 2, 0, -1);
    pin("gap_wr_ready_cnt", n_wrr - s_wrr, 4);

    // back-to-back, length clamp and zero length
    snap();
    run_txn(1, 32'h200, 2, 0, 0, 0, -1, 0, 0, -1);
    run_txn(0, 32'h300, 2, 0, 0, 0, -1, 0, 0, -1);
    pin("b2b_busy_cycles", n_busy - s_busy, 8);
    snap();
    run_txn(0, 32'h400, 20, 0, 0, 0, -1, 0, 0, -1);
    pin("clamp_rd_valid_cnt", n_rdv - s_rdv, 16);
    snap();
    run_txn(1, 32'h500, 0, 0, 0, 0, -1, 0, 0, -1);
    pin("len0_wr_ready_cnt", n_wrr - s_wrr, 1);

    // reset during the second beat, then a normal request
    snap();
    run_txn(1, 32'h600, 4, 0, 0, 0, -1, 0, 0, 1);
    pin("rst_no_done", n_done - s_done, 0);
    snap();
    run_txn(1, 32'h700, 2, 0, 0, 0, -1, 0, 0, -1);
    pin("post_rst_done", n_done - s_done, 1);
    pin("post_rst_wr_ready", n_wrr - s_wrr, 2);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      int dly;
      dly = ($urandom_range(9) == 0) ? 100 : int'($urandom_range(5));
      run_txn(1'($urandom()), $urandom(), LEN_W'($urandom_range(20)), dly,
              int'($urandom_range(2)), 30, -1, 0, 30, -1);
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
